// File: rtl/riscv_dcache_fsm_if.sv
// riscv_dcache_fsm_if: CPU, tag-array, data-array and DRAM handshake signals of the L1 D-cache controller
interface riscv_dcache_fsm_if;
    logic cpu_rden;
    logic cpu_wren;
    logic hit;
    logic dirty;
    logic mem_ready;
    logic stall;
    logic cache_rden;
    logic cache_wren;
    logic mem_in;
    logic tag_wren;
    logic set_dirty;
    logic clr_dirty;
    logic mem_rden;
    logic mem_wren;
    logic victim_sel;

    modport master (
        output cpu_rden, cpu_wren, hit, dirty, mem_ready,
        input  stall, cache_rden, cache_wren, mem_in, tag_wren,
               set_dirty, clr_dirty, mem_rden, mem_wren, victim_sel
    );

    modport slave (
        input  cpu_rden, cpu_wren, hit, dirty, mem_ready,
        output stall, cache_rden, cache_wren, mem_in, tag_wren,
               set_dirty, clr_dirty, mem_rden, mem_wren, victim_sel
    );
endinterface

// File: rtl/riscv_dcache_fsm.sv
// riscv_dcache_fsm: direct-mapped write-back write-allocate L1 D-cache sequencer; DCACHE_PERF_CNT_EN adds hit/miss counters
module riscv_dcache_fsm
`ifdef DCACHE_PERF_CNT_EN
#(
    parameter int CNT_WIDTH = 32
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    riscv_dcache_fsm_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE, REFILL} state_t;

    state_t state_q, state_d;
    logic   req;
    logic   wr;

    assign req = bus.cpu_rden | bus.cpu_wren;
    assign wr  = bus.cpu_wren;

    // state register; reset abandons any DRAM transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state and outputs; everything is forced low while reset is asserted
    always_comb begin
        state_d        = state_q;
        bus.stall      = 1'b0;
        bus.cache_rden = 1'b0;
        bus.cache_wren = 1'b0;
        bus.mem_in     = 1'b0;
        bus.tag_wren   = 1'b0;
        bus.set_dirty  = 1'b0;
        bus.clr_dirty  = 1'b0;
        bus.mem_rden   = 1'b0;
        bus.mem_wren   = 1'b0;
        bus.victim_sel = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req && bus.hit) begin
                        bus.cache_rden = !wr;
                        bus.cache_wren = wr;
                        bus.set_dirty  = wr;
                    end else if (req) begin
                        bus.stall = 1'b1;
                        state_d   = bus.dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    bus.stall      = 1'b1;
                    bus.cache_rden = 1'b1;
                    bus.mem_wren   = 1'b1;
                    bus.victim_sel = 1'b1;
                    bus.clr_dirty  = bus.mem_ready;
                    state_d        = bus.mem_ready ? ALLOCATE : WRITE_BACK;
                end
                ALLOCATE: begin
                    bus.stall    = 1'b1;
                    bus.mem_rden = 1'b1;
                    state_d      = bus.mem_ready ? REFILL : ALLOCATE;
                end
                default: begin
                    bus.stall      = 1'b1;
                    bus.cache_wren = 1'b1;
                    bus.mem_in     = 1'b1;
                    bus.tag_wren   = 1'b1;
                    bus.clr_dirty  = 1'b1;
                    state_d        = IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // performance counters: hits (including replays) and misses leaving IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == IDLE && req) begin
            hit_cnt  <= hit_cnt + CNT_WIDTH'(bus.hit);
            miss_cnt <= miss_cnt + CNT_WIDTH'(!bus.hit);
        end
    end
`endif
endmodule
